stream_converge_arb: RTL and testbench

Parametrised successor to the converged-stream controller. Merges freespace-update packets from `NUM_IN_PORTS` input ports and data packets from `NUM_OUT_PORTS` output-port FIFOs into one registered stream. Update packets have strict priority. Data ports are served by empty-aware round-robin instead of blind polling. Sits between the leaf port FIFOs and the shared upstream link, and supports link-level resend hold/replay.

---
 rtl/converge_pkg.sv | 23 ++
 rtl/SynFIFO.sv | 50 +++++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/stream_converge_arb.sv | 162 ++++++++++++++++
 tb/tb_stream_converge_arb.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/converge_pkg.sv
// Shared types and helpers for the converged-stream arbiter.
// Contents: default packet geometry, issue-source enum, port index width helper.
package converge_pkg;

  localparam int unsigned PKT_BITS_DEFAULT = 97;
  // MSB of a packet is its valid bit.
  localparam int unsigned PKT_VALID_BIT    = PKT_BITS_DEFAULT - 1;

  // What was issued in the previous cycle, selecting the output mux leg.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    UPD  = 2'd1,
    PORT = 2'd2
  } src_t;

  // Index width able to address the larger of the two port groups.
  function automatic int unsigned port_bits(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/SynFIFO.sv
// Synchronous FIFO, registered read data (latency 1).
// Ports: clk, reset (sync, active-high), wr_en/wdata write side,
// rd_en/rdata read side, full/empty status.
module SynFIFO #(
  parameter int unsigned DSIZE = 97,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      rdata <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (ASIZE+1)'(1);
      if (do_rd) begin
        rdata <= mem[rptr[ASIZE-1:0]];
        rptr  <= rptr + (ASIZE+1)'(1);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the lowest requester at or above the
// pointer, else the lowest requester overall. Pointer moves to grant+1.
// Ports: clk, reset, req, en (grant qualifier), grant (one-hot), grant_idx.
module rr_arbiter #(
  parameter  int unsigned N  = 7,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  logic          fire;

  // Two-pass search: wrap-around region only if nothing at/above pointer.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IW'(i) >= ptr)) begin
        found     = 1'b1;
        grant_idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end

  assign fire  = en && (|req);
  assign grant = fire ? (N'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (grant_idx == IW'(N-1)) ? '0 : IW'(grant_idx + IW'(1));
    end
  end

endmodule

// File: rtl/stream_converge_arb.sv
// Merges freespace-update packets (strict priority, via an update FIFO)
// and round-robin data-port packets into one registered stream, with
// link-level resend hold/replay.
// Ports: clk, reset (sync, active-high), freespace_update levels and
// payloads, data FIFO douts/empty flags, resend; outport_sel (comb read
// strobe), stream_out (registered), upd_overflow (sticky).
module stream_converge_arb
  import converge_pkg::*;
#(
  parameter int unsigned PACKET_BITS    = 97,
  parameter int unsigned NUM_IN_PORTS   = 7,
  parameter int unsigned NUM_OUT_PORTS  = 7,
  parameter int unsigned UPD_FIFO_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_IN_PORTS-1:0]              freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]  packet_from_input_ports,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] packet_from_output_ports,
  input  logic [NUM_OUT_PORTS-1:0]             empty,
  input  logic                                 resend,
  output logic [NUM_OUT_PORTS-1:0]             outport_sel,
  output logic [PACKET_BITS-1:0]               stream_out,
  output logic                                 upd_overflow
);

  localparam int unsigned PB     = port_bits(NUM_IN_PORTS, NUM_OUT_PORTS);
  localparam int unsigned IN_IW  = (NUM_IN_PORTS  > 1) ? $clog2(NUM_IN_PORTS)  : 1;
  localparam int unsigned OUT_IW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int unsigned ASIZE  = $clog2(UPD_FIFO_DEPTH);

  logic [NUM_IN_PORTS-1:0]  upd_prev;
  logic [NUM_IN_PORTS-1:0]  upd_edge;
  logic [NUM_IN_PORTS-1:0]  pend;
  logic [PACKET_BITS-1:0]   slot [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0]  drain_grant;
  logic [IN_IW-1:0]         drain_idx;
  logic [NUM_OUT_PORTS-1:0] out_grant;
  logic [OUT_IW-1:0]        out_idx;
  logic [PACKET_BITS-1:0]   fifo_wdata;
  logic [PACKET_BITS-1:0]   fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_rd;
  logic                     hold;
  logic                     resend_d;
  src_t                     src_d;
  logic [PB-1:0]            src_idx;
  logic [PACKET_BITS-1:0]   nxt;
  logic [PACKET_BITS-1:0]   tmp;

  assign upd_edge = freespace_update & ~upd_prev;

  // Update capture: a new edge always wins the slot; it only counts as an
  // overflow if the old payload was not being drained this same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_prev     <= '0;
      pend         <= '0;
      upd_overflow <= 1'b0;
      for (int i = 0; i < NUM_IN_PORTS; i++) slot[i] <= '0;
    end else begin
      upd_prev <= freespace_update;
      pend     <= (pend & ~drain_grant) | upd_edge;
      if (|(upd_edge & pend & ~drain_grant)) upd_overflow <= 1'b1;
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (upd_edge[i]) slot[i] <= packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS];
      end
    end
  end

  // Drain pending slots into the update FIFO while it has room.
  rr_arbiter #(.N(NUM_IN_PORTS)) u_drain_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (pend),
    .en        (!fifo_full),
    .grant     (drain_grant),
    .grant_idx (drain_idx)
  );

  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (drain_idx == IN_IW'(i)) fifo_wdata = slot[i];
    end
  end

  SynFIFO #(.DSIZE(PACKET_BITS), .ASIZE(ASIZE)) u_upd_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (|drain_grant),
    .wdata (fifo_wdata),
    .rd_en (fifo_rd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue: updates first, then non-empty data ports; nothing while holding.
  assign hold    = resend | resend_d;
  assign fifo_rd = !hold && !fifo_empty;

  rr_arbiter #(.N(NUM_OUT_PORTS)) u_issue_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (~empty),
    .en        (!hold && fifo_empty),
    .grant     (out_grant),
    .grant_idx (out_idx)
  );

  assign outport_sel = out_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_d   <= NONE;
      src_idx <= '0;
    end else if (fifo_rd) begin
      src_d <= UPD;
    end else if (|out_grant) begin
      src_d   <= PORT;
      src_idx <= PB'(out_idx);
    end else begin
      src_d <= NONE;
    end
  end

  // Read data arrives one cycle after issue; pick the matching source.
  always_comb begin
    nxt = '0;
    case (src_d)
      UPD: nxt = fifo_rdata;
      PORT: begin
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
          if (src_idx == PB'(j)) nxt = packet_from_output_ports[j*PACKET_BITS +: PACKET_BITS];
        end
      end
      default: nxt = '0;
    endcase
  end

  // Resend: park the in-flight word on the rising edge, replay it on the fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      resend_d   <= 1'b0;
      tmp        <= '0;
      stream_out <= '0;
    end else begin
      resend_d <= resend;
      if (resend && !resend_d) begin
        tmp <= nxt;
      end else if (!resend && resend_d) begin
        stream_out <= tmp;
        tmp        <= '0;
      end else if (!resend) begin
        stream_out <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_stream_converge_arb.sv
// Scoreboard bench for stream_converge_arb: directed phases push hand-ordered
// expected packets; a negedge monitor pops and compares each new valid word.
module tb_stream_converge_arb;

  localparam int W  = 97;
  localparam int NI = 7;
  localparam int NO = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] fs;
  logic [NO-1:0] empty;
  logic          resend;
  logic [NO-1:0] outport_sel;
  logic [W-1:0]  stream_out;
  logic          upd_overflow;

  logic [W-1:0]    upd_pl   [NI] = '{default: '0};
  logic [W-1:0]    port_out [NO] = '{default: '0};
  int              gen_cnt  [NO] = '{default: 0};
  logic [W*NI-1:0] pin;
  logic [W*NO-1:0] pout;

  logic [W-1:0] exp_q [$];
  int           checks = 0;
  int           errors = 0;
  logic         prev_resend = 1'b0;
  logic         prev_reset  = 1'b1;
  logic [W-1:0] last_out    = '0;

  logic [6:0] seq1 [5] = '{7'd1, 7'd4, 7'd16, 7'd64, 7'd1};
  logic [6:0] seq2 [6] = '{7'd2, 7'd4, 7'd8, 7'd0, 7'd0, 7'd16};
  int         order [7] = '{6, 0, 1, 2, 3, 4, 5};

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NI; i++) pin[i*W +: W] = upd_pl[i];
    for (int j = 0; j < NO; j++) pout[j*W +: W] = port_out[j];
  end

  stream_converge_arb dut (
    .clk                      (clk),
    .reset                    (reset),
    .freespace_update         (fs),
    .packet_from_input_ports  (pin),
    .packet_from_output_ports (pout),
    .empty                    (empty),
    .resend                   (resend),
    .outport_sel              (outport_sel),
    .stream_out               (stream_out),
    .upd_overflow             (upd_overflow)
  );

  function automatic logic [W-1:0] dpkt(input int p, input int n);
    logic [W-1:0] r;
    r        = '0;
    r[W-1]   = 1'b1;
    r[95:88] = 8'hDA;
    r[79:48] = 32'(p * 1000 + n + 7);
    r[15:8]  = 8'(p);
    r[7:0]   = 8'(n);
    return r;
  endfunction

  function automatic logic [W-1:0] upkt(input int p, input int b);
    logic [W-1:0] r;
    r        = '0;
    r[W-1]   = 1'b1;
    r[95:88] = 8'hC5;
    r[70:39] = 32'(b * 4099 + p * 13 + 1);
    r[15:8]  = 8'(p);
    r[7:0]   = 8'(b);
    return r;
  endfunction

  // Data port FIFOs: one new word per read strobe, visible next cycle.
  always @(posedge clk) begin
    for (int j = 0; j < NO; j++) begin
      if (outport_sel[j]) begin
        port_out[j] <= dpkt(j, gen_cnt[j]);
        gen_cnt[j]  <= gen_cnt[j] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // A new word lands on stream_out only after a cycle with resend low;
  // after a resend-high cycle the output must be frozen.
  always @(negedge clk) begin
    if (!reset && !prev_reset) begin
      if (prev_resend) begin
        chk("frozen", stream_out, last_out);
      end else if (stream_out[W-1]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out actual=%h required=none", stream_out);
        end else if (stream_out !== exp_q[0]) begin
          errors++;
          $display("FAIL stream actual=%h required=%h", stream_out, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    prev_resend <= resend;
    prev_reset  <= reset;
    last_out    <= stream_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    fs     = '0;
    empty  = '1;
    resend = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stream", stream_out, '0);
    chk("rst_ovf", W'(upd_overflow), '0);
    chk("rst_sel", W'(outport_sel), '0);

    // Round-robin skip over ports 1, 3, 5 (empty).
    exp_q.push_back(dpkt(0, 0));
    exp_q.push_back(dpkt(2, 0));
    exp_q.push_back(dpkt(4, 0));
    exp_q.push_back(dpkt(6, 0));
    exp_q.push_back(dpkt(0, 1));
    for (int k = 0; k < 5; k++) begin
      step();
      empty = 7'b0101010;
      @(negedge clk);
      chk("rr_sel", W'(outport_sel), W'(seq1[k]));
    end
    step();
    empty = '1;
    @(negedge clk);
    chk("rr_stop_sel", W'(outport_sel), '0);
    repeat (2) step();

    // All ports empty, no updates.
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("idle_sel", W'(outport_sel), '0);
      chk("idle_stream", stream_out, '0);
    end

    // Update priority over flowing data.
    exp_q.push_back(dpkt(1, 0));
    exp_q.push_back(dpkt(2, 1));
    exp_q.push_back(dpkt(3, 0));
    exp_q.push_back(upkt(2, 0));
    exp_q.push_back(upkt(5, 0));
    exp_q.push_back(dpkt(4, 1));
    for (int k = 0; k < 6; k++) begin
      step();
      empty = '0;
      if (k == 1) begin
        upd_pl[2] = upkt(2, 0);
        upd_pl[5] = upkt(5, 0);
        fs        = 7'b0100100;
      end
      if (k == 3) fs = '0;
      @(negedge clk);
      chk("prio_sel", W'(outport_sel), W'(seq2[k]));
    end
    step();
    empty = '1;
    repeat (4) step();

    // Overflow: fill the FIFO under hold, then double-pulse in-port 3.
    step();
    resend = 1'b1;
    for (int b = 1; b <= 2; b++) begin
      step();
      for (int i = 0; i < NI; i++) upd_pl[i] = upkt(i, b);
      fs = '1;
      step();
      fs = '0;
      repeat (9) step();
    end
    step();
    upd_pl[0] = upkt(0, 3);
    upd_pl[1] = upkt(1, 3);
    fs = 7'b0000011;
    step();
    fs = '0;
    repeat (4) step();
    @(negedge clk);
    chk("ovf_full_pre", W'(upd_overflow), '0);
    step();
    upd_pl[3] = upkt(3, 8);
    fs = 7'b0001000;
    step();
    fs = '0;
    step();
    @(negedge clk);
    chk("ovf_first_pulse", W'(upd_overflow), '0);
    step();
    upd_pl[3] = upkt(3, 9);
    fs = 7'b0001000;
    step();
    fs = '0;
    @(negedge clk);
    chk("ovf_set", W'(upd_overflow), W'(1));
    for (int b = 1; b <= 2; b++)
      for (int k = 0; k < 7; k++) exp_q.push_back(upkt(order[k], b));
    exp_q.push_back(upkt(0, 3));
    exp_q.push_back(upkt(1, 3));
    exp_q.push_back(upkt(3, 9));
    step();
    resend = 1'b0;
    repeat (22) step();
    @(negedge clk);
    chk("ovf_sticky", W'(upd_overflow), W'(1));

    // Resend: B at t-1, A at t, resend high t+1..t+4.
    exp_q.push_back(dpkt(0, 2));
    exp_q.push_back(dpkt(0, 3));
    for (int k = 0; k < 2; k++) begin
      step();
      empty = 7'b1111110;
      @(negedge clk);
      chk("rs_issue_sel", W'(outport_sel), W'(1));
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      empty  = '1;
      resend = (k <= 4);
      @(negedge clk);
      chk("rs_hold_sel", W'(outport_sel), '0);
    end
    repeat (4) step();

    // Mid-stream reset with three queued updates.
    step();
    resend = 1'b1;
    step();
    for (int i = 0; i < 3; i++) upd_pl[i] = upkt(i, 5);
    fs = 7'b0000111;
    step();
    fs = '0;
    repeat (4) step();
    step();
    reset  = 1'b1;
    resend = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_stream", stream_out, '0);
    chk("mrst_ovf", W'(upd_overflow), '0);
    repeat (6) step();
    exp_q.push_back(dpkt(0, 4));
    step();
    empty = '0;
    @(negedge clk);
    chk("mrst_rr_restart", W'(outport_sel), W'(1));
    step();
    empty = '1;
    repeat (4) step();
    @(negedge clk);
    chk("leftover", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
